// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO byte transmitter: default register
// addresses, status register layout, serializer states and small helpers.
package mmio_pkg;

    localparam logic [31:0] DEF_DATA_ADDR = 32'h1081_0000;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h1081_0004;

    // Status register layout: {23'b0, busy, overflow, full, empty, count[4:0]}
    localparam int STAT_CNT_W     = 5;
    localparam int STAT_EMPTY_BIT = 5;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_OVF_BIT   = 7;
    localparam int STAT_BUSY_BIT  = 8;

    // Bit of a status-register write that clears the sticky overflow flag
    localparam int CLR_OVF_BIT = 0;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    // Byte of a word in network order: index 0 is the most significant byte
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Assemble the status register word from its fields
    function automatic logic [31:0] pack_status(input logic busy, input logic ovf,
                                                input logic full, input logic empty,
                                                input logic [STAT_CNT_W-1:0] cnt);
        logic [31:0] s;
        s = 32'h0000_0000;
        s[STAT_CNT_W-1:0]  = cnt;
        s[STAT_EMPTY_BIT]  = empty;
        s[STAT_FULL_BIT]   = full;
        s[STAT_OVF_BIT]    = ovf;
        s[STAT_BUSY_BIT]   = busy;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Pointers wrap modulo DEPTH
// (power of two); a push into a full FIFO is accepted only when a pop
// happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign count     = count_r;
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rdata     = mem[rd_ptr_r];

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_tx_fifo.sv
// CPU-facing transmit FIFO: words written to DATA_ADDR are queued and
// serialized most-significant byte first onto a valid/ready byte stream.
// STAT_ADDR reads back queue state and clears the sticky overflow flag.
module mmio_tx_fifo
    import mmio_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] DATA_ADDR = DEF_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR = DEF_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        cs,
    input  logic        sig_w,
    input  logic        sig_r,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push_req_s;
    logic          stat_rd_s;
    logic          clr_ovf_s;
    logic          ovf_set_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [31:0]   head_s;

    ser_state_e    state_r;
    logic [1:0]    idx_r;
    logic [31:0]   shreg_r;
    logic [7:0]    tx_data_r;
    logic          tx_valid_r;
    logic          ovf_r;

    assign push_req_s = cs & sig_w & (addr == DATA_ADDR);
    assign clr_ovf_s  = cs & sig_w & (addr == STAT_ADDR) & wdata[CLR_OVF_BIT];
    assign stat_rd_s  = cs & sig_r & (addr == STAT_ADDR);
    assign ovf_set_s  = push_req_s & fifo_full_s & ~pop_s;
    assign tx_data    = tx_data_r;
    assign tx_valid   = tx_valid_r;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req_s),
        .pop   (pop_s),
        .wdata (wdata),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Pop a new word when idle, or when the last byte of the current word is taken
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            SER_IDLE:  pop_s = ~fifo_empty_s;
            SER_SHIFT: pop_s = tx_ready & (idx_r == 2'd3) & ~fifo_empty_s;
            default:   pop_s = 1'b0;
        endcase
    end

    // Serializer: loads words from the FIFO and steps through their bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= SER_IDLE;
            idx_r      <= 2'd0;
            shreg_r    <= 32'h0000_0000;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            case (state_r)
                SER_IDLE: begin
                    if (!fifo_empty_s) begin
                        shreg_r    <= head_s;
                        idx_r      <= 2'd0;
                        tx_data_r  <= byte_sel(head_s, 2'd0);
                        tx_valid_r <= 1'b1;
                        state_r    <= SER_SHIFT;
                    end else begin
                        tx_valid_r <= 1'b0;
                    end
                end
                SER_SHIFT: begin
                    if (!tx_ready) begin
                        tx_valid_r <= 1'b1;
                    end else if (idx_r != 2'd3) begin
                        idx_r     <= idx_r + 2'd1;
                        tx_data_r <= byte_sel(shreg_r, idx_r + 2'd1);
                    end else if (!fifo_empty_s) begin
                        // Next word follows immediately so the stream has no gap
                        shreg_r   <= head_s;
                        idx_r     <= 2'd0;
                        tx_data_r <= byte_sel(head_s, 2'd0);
                    end else begin
                        idx_r      <= 2'd0;
                        tx_valid_r <= 1'b0;
                        state_r    <= SER_IDLE;
                    end
                end
                default: begin
                    idx_r      <= 2'd0;
                    tx_valid_r <= 1'b0;
                    state_r    <= SER_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag; a new drop wins over a same-edge clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (clr_ovf_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Status register read path
    always_comb begin
        rdata = 32'h0000_0000;
        if (stat_rd_s) begin
            rdata = pack_status(state_r != SER_IDLE, ovf_r, fifo_full_s, fifo_empty_s,
                                STAT_CNT_W'(fifo_count_s));
        end else begin
            rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_mmio_tx_fifo.sv
// Self-checking bench for mmio_tx_fifo: a word-queue / byte-queue model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mmio_tx_fifo;
    localparam int          DEPTH = 16;
    localparam logic [31:0] DADDR = 32'h1081_0000;
    localparam logic [31:0] SADDR = 32'h1081_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        cs;
    logic        sig_w;
    logic        sig_r;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mmio_tx_fifo #(.DEPTH(DEPTH), .DATA_ADDR(DADDR), .STAT_ADDR(SADDR)) dut (
        .clk(clk), .rst(rst), .addr(addr), .cs(cs), .sig_w(sig_w), .sig_r(sig_r),
        .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_words[$];   // queued words
    logic [7:0]  m_bytes[$];   // bytes of the word currently being sent
    bit          m_ovf;
    bit          m_active, m_consume, m_fin, m_pop, m_full, m_push, m_clr;
    logic [31:0] m_w;

    always @(posedge clk) begin
        if (rst) begin
            m_words.delete();
            m_bytes.delete();
            m_ovf = 1'b0;
        end else begin
            m_active  = (m_bytes.size() != 0);
            m_consume = m_active && tx_ready;
            m_fin     = !m_active || (m_consume && m_bytes.size() == 1);
            m_pop     = m_fin && (m_words.size() != 0);
            m_full    = (m_words.size() == DEPTH);
            m_push    = cs && sig_w && (addr == DADDR);
            m_clr     = cs && sig_w && (addr == SADDR) && wdata[0];
            if (m_consume) void'(m_bytes.pop_front());
            if (m_pop) begin
                m_w = m_words.pop_front();
                m_bytes.push_back(m_w[31:24]);
                m_bytes.push_back(m_w[23:16]);
                m_bytes.push_back(m_w[15:8]);
                m_bytes.push_back(m_w[7:0]);
            end
            if (m_clr) m_ovf = 1'b0;
            if (m_push) begin
                if (!m_full || m_pop) m_words.push_back(wdata);
                else m_ovf = 1'b1;
            end
        end
    end

    function automatic logic [31:0] model_rdata();
        logic [31:0] s;
        s = 32'h0;
        if (cs && sig_r && addr == SADDR) begin
            s[8]   = (m_bytes.size() != 0);
            s[7]   = m_ovf;
            s[6]   = (m_words.size() == DEPTH);
            s[5]   = (m_words.size() == 0);
            s[4:0] = 5'(m_words.size());
        end
        return s;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx_valid", {31'b0, tx_valid}, {31'b0, (m_bytes.size() != 0)});
            if (m_bytes.size() != 0) check("model_tx_data", {24'b0, tx_data}, {24'b0, m_bytes[0]});
            check("model_rdata", rdata, model_rdata());
        end
    end

    // Record every byte the transmitter accepts
    logic [7:0] seen_q[$];
    int         seen_cyc[$];
    int         cyc = 0;
    always @(negedge clk) begin
        cyc++;
        if (chk_en && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            seen_q.push_back(tx_data);
            seen_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cs = 1'b1; sig_w = 1'b0; sig_r = 1'b1; addr = SADDR; wdata = 32'h0;
    endtask

    task automatic push_word(input logic [31:0] w);
        cs = 1'b1; sig_w = 1'b1; sig_r = 1'b1; addr = DADDR; wdata = w;
        cycle();
        bus_idle();
    endtask

    logic [7:0] exp_c [12] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h01, 8'h02,
                               8'h03, 8'h04, 8'h88, 8'h99, 8'hAA, 8'hBB};
    logic [7:0] exp_a [4]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        rst = 1'b1; tx_ready = 1'b0;
        bus_idle();
        cycle();
        cycle();
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("reset_tx_data", {24'b0, tx_data}, 32'h0);
        check("reset_status", rdata, 32'h0000_0020);
        cycle();
        rst = 1'b0;
        cycle();

        // Single word, ready held high
        tx_ready = 1'b1;
        push_word(32'hA1B2_C3D4);
        @(negedge clk);
        check("a_pre_valid", {31'b0, tx_valid}, 32'h0);
        check("a_pre_status", rdata, 32'h0000_0001);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("a_valid", {31'b0, tx_valid}, 32'h1);
            check("a_byte", {24'b0, tx_data}, {24'b0, exp_a[k]});
        end
        @(negedge clk);
        check("a_end_valid", {31'b0, tx_valid}, 32'h0);
        check("a_end_status", rdata, 32'h0000_0020);
        cycle();

        // Back-pressure mid-word
        push_word(32'h1122_3344);
        @(negedge clk);
        @(negedge clk);
        check("b_byte0", {24'b0, tx_data}, 32'h11);
        @(negedge clk);
        check("b_byte1", {24'b0, tx_data}, 32'h22);
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("b_hold_data", {24'b0, tx_data}, 32'h22);
            check("b_hold_valid", {31'b0, tx_valid}, 32'h1);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("b_byte2", {24'b0, tx_data}, 32'h33);
        @(negedge clk);
        check("b_byte3", {24'b0, tx_data}, 32'h44);
        @(negedge clk);
        check("b_end_valid", {31'b0, tx_valid}, 32'h0);
        cycle();

        // Three words streamed without gaps
        seen_q.delete(); seen_cyc.delete();
        push_word(32'hCAFE_F00D);
        push_word(32'h0102_0304);
        push_word(32'h8899_AABB);
        repeat (16) cycle();
        check("c_count", seen_q.size(), 32'd12);
        if (seen_q.size() == 12) begin
            check("c_no_gap", seen_cyc[11] - seen_cyc[0], 32'd11);
            for (int k = 0; k < 12; k++) check("c_byte", {24'b0, seen_q[k]}, {24'b0, exp_c[k]});
        end

        // Fill to full, overflow, clear, push-with-pop on full
        tx_ready = 1'b0;
        for (int k = 0; k < 17; k++) push_word(32'h100 + k);
        @(negedge clk);
        check("d_full_status", rdata, 32'h0000_0150);
        cycle();
        push_word(32'h0000_0999);
        @(negedge clk);
        check("d_ovf_status", rdata, 32'h0000_01D0);
        cycle();
        cs = 1'b1; sig_w = 1'b1; addr = SADDR; wdata = 32'h0000_0001;
        cycle();
        bus_idle();
        @(negedge clk);
        check("d_clr_status", rdata, 32'h0000_0150);
        cycle();
        seen_q.delete(); seen_cyc.delete();
        tx_ready = 1'b1;
        cycle(); cycle(); cycle();
        push_word(32'hDEAD_BEEF);
        @(negedge clk);
        check("d_pushpop_status", rdata, 32'h0000_0150);
        repeat (90) cycle();
        check("d_drain_count", seen_q.size(), 32'd72);
        if (seen_q.size() == 72) begin
            check("d_first", {seen_q[0], seen_q[1], seen_q[2], seen_q[3]}, 32'h0000_0100);
            check("d_w16", {seen_q[64], seen_q[65], seen_q[66], seen_q[67]}, 32'h0000_0110);
            check("d_last", {seen_q[68], seen_q[69], seen_q[70], seen_q[71]}, 32'hDEAD_BEEF);
        end

        // Reset in the middle of a burst
        tx_ready = 1'b0;
        push_word(32'h5566_7788);
        push_word(32'h99AA_BBCC);
        push_word(32'h1357_9BDF);
        push_word(32'h2468_ACE0);
        seen_q.delete(); seen_cyc.delete();
        tx_ready = 1'b1;
        begin
            int waited;
            waited = 0;
            while (seen_q.size() < 2 && waited < 20) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check("e_two_bytes_seen", {31'b0, (seen_q.size() >= 2)}, 32'h1);
        end
        rst = 1'b1;
        @(negedge clk);
        check("e_rst_valid", {31'b0, tx_valid}, 32'h0);
        check("e_rst_status", rdata, 32'h0000_0020);
        rst = 1'b0;
        repeat (10) cycle();
        check("e_no_more_bytes", seen_q.size(), 32'd2);
        if (seen_q.size() == 2) check("e_bytes", {16'b0, seen_q[0], seen_q[1]}, 32'h0000_5566);

        // Decode misses: no select, wrong address, no read strobe
        cs = 1'b0; sig_w = 1'b1; addr = DADDR; wdata = 32'h7777_7777;
        cycle();
        cs = 1'b1; sig_w = 1'b1; addr = 32'h1081_0008; wdata = 32'h6666_6666;
        cycle();
        bus_idle();
        @(negedge clk);
        check("f_no_push_status", rdata, 32'h0000_0020);
        check("f_no_push_valid", {31'b0, tx_valid}, 32'h0);
        cycle();
        sig_r = 1'b0;
        @(negedge clk);
        check("f_no_read", rdata, 32'h0);
        cycle();
        bus_idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: run did not finish, expected completion before %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_tx_fifo.md
MMIO_TX_FIFO -- requirements
Module: mmio_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in 32-bit words (power of two).
REQ-002 SHALL have parameter DATA_ADDR, default 32'h10810000, word-push register address.
REQ-003 SHALL have parameter STAT_ADDR, default 32'h10810004, status/control register address.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port addr  input  32  CPU byte address.
REQ-007 SHALL have port cs  input  1  peripheral select, driven by the upstream address decoder's vga_cs.
REQ-008 SHALL have port sig_w  input  1  CPU write strobe.
REQ-009 SHALL have port sig_r  input  1  CPU read strobe.
REQ-010 SHALL have port wdata  input  32  CPU write data.
REQ-011 SHALL have port rdata  output  32  CPU read data.
REQ-012 SHALL have port tx_data  output  8  byte stream to the transmitter.
REQ-013 SHALL have port tx_valid  output  1  tx_data valid.
REQ-014 SHALL have port tx_ready  input  1  transmitter accepts a byte.

Function
REQ-015 push = cs & sig_w & addr==DATA_ADDR; wdata is written into the FIFO tail on that edge if not full, or if full with a pop on the same edge.
REQ-016 A push onto a full FIFO with no same-edge pop SHALL be dropped and SHALL set the sticky overflow flag.
REQ-017 cs & sig_w & addr==STAT_ADDR with wdata[0]=1 SHALL clear overflow; all other wdata bits are ignored.
REQ-018 If a clear and a new overflow occur on the same edge, overflow SHALL end set.
REQ-019 rdata SHALL be combinational: when cs & sig_r & addr==STAT_ADDR, {23'b0, busy, overflow, full, empty, count[4:0]}; otherwise 32'h0.
REQ-020 count SHALL range 0..DEPTH; empty = (count==0); full = (count==DEPTH); busy = serializer state != IDLE.
REQ-021 Serializer FSM SHALL have states IDLE and SHIFT.
REQ-022 In IDLE with FIFO non-empty: pop head into a 32-bit shift register, byte index := 0, go to SHIFT.
REQ-023 In SHIFT: tx_valid=1; tx_data = byte selected by index, index 0 = bits [31:24] (big-endian, network order).
REQ-024 On tx_valid & tx_ready with index<3: index increments; with index==3: pop next word and remain in SHIFT if FIFO non-empty, else go to IDLE.
REQ-025 tx_data and tx_valid SHALL stay stable while tx_valid & !tx_ready.
REQ-026 Latency: push at edge N into an empty FIFO with serializer idle -> tx_valid high after edge N+1; back-to-back words SHALL stream with no idle cycle when tx_ready is held high.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; count SHALL be unchanged on a simultaneous push and pop.

Reset
REQ-028 rst high at an edge SHALL set count=0, read/write pointers=0, overflow=0, state=IDLE, index=0, shift register=0.
REQ-029 After reset: tx_valid=0, tx_data=8'h00; rdata follows REQ-019 (empty=1).
REQ-030 Reset mid-transfer SHALL discard all queued words and any partially sent word without emitting further bytes.
REQ-031 rst SHALL take priority over push, pop and clear on the same edge.

Structure
REQ-032 Default addresses, status bit positions and FSM state encodings SHALL reside in a shared package, mmio_pkg.
REQ-033 FIFO storage and pointers SHALL be a sub-module sync_fifo (width 32, depth DEPTH, push/pop/full/empty/count); the FSM and register decode stay in mmio_tx_fifo.

Verification
REQ-034 Push 32'hA1B2C3D4, tx_ready=1 -> bytes A1,B2,C3,D4 on four consecutive cycles starting two edges after the push; then tx_valid=0, busy=0.
REQ-035 Push 17 words with tx_ready=0 -> first word popped into the shift register, 16 queued, full=1; 18th push dropped, overflow=1; write STAT_ADDR 32'h1 -> overflow=0.
REQ-036 Hold tx_ready=0 for 5 cycles mid-word -> tx_data/tx_valid unchanged; resumes with the next byte.
REQ-037 Push 3 words with tx_ready=1 continuously -> 12 bytes with tx_valid never dropping.
REQ-038 Assert rst after 2 bytes of a 4-word burst -> next cycle tx_valid=0, status read = 32'h00000020.
REQ-039 Push with cs=0 or addr=32'h10810008 -> no FIFO change; status read with sig_r=0 -> rdata=0.
